// File: rtl/eth_axis_pkg.sv
// Shared definitions for the 256-bit AXI4-Stream Ethernet datapath blocks.
package eth_axis_pkg;

  localparam int unsigned ETH_DATA_W = 256;
  localparam int unsigned ETH_KEEP_W = 32;

  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;

endpackage

// File: rtl/eth_axis_skid_256b.sv
// Two-entry register slice for a 256-bit AXI4-Stream beat plus source tag.
// The output register is the queue head, so s_ready is registered and never sees m_ready.
module eth_axis_skid_256b
  import eth_axis_pkg::*;
#(
  parameter int unsigned TID_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ETH_DATA_W-1:0] s_data,
  input  logic [ETH_KEEP_W-1:0] s_keep,
  input  logic                  s_last,
  input  logic [TID_W-1:0]      s_tid,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ETH_DATA_W-1:0] m_data,
  output logic [ETH_KEEP_W-1:0] m_keep,
  output logic                  m_last,
  output logic [TID_W-1:0]      m_tid,
  output logic                  m_valid,
  input  logic                  m_ready
);

  logic [ETH_DATA_W-1:0] head_data_q, head_data_d, spare_data_q, spare_data_d;
  logic [ETH_KEEP_W-1:0] head_keep_q, head_keep_d, spare_keep_q, spare_keep_d;
  logic                  head_last_q, head_last_d, spare_last_q, spare_last_d;
  logic [TID_W-1:0]      head_tid_q, head_tid_d, spare_tid_q, spare_tid_d;
  logic                  head_valid_q, head_valid_d, spare_valid_q, spare_valid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  push, pop;

  always_comb begin
    head_data_d   = head_data_q;
    head_keep_d   = head_keep_q;
    head_last_d   = head_last_q;
    head_tid_d    = head_tid_q;
    head_valid_d  = head_valid_q;
    spare_data_d  = spare_data_q;
    spare_keep_d  = spare_keep_q;
    spare_last_d  = spare_last_q;
    spare_tid_d   = spare_tid_q;
    spare_valid_d = spare_valid_q;
    push          = s_valid && s_ready_q;
    pop           = head_valid_q && m_ready;

    if (!head_valid_q || pop) begin
      if (spare_valid_q) begin
        head_data_d   = spare_data_q;
        head_keep_d   = spare_keep_q;
        head_last_d   = spare_last_q;
        head_tid_d    = spare_tid_q;
        head_valid_d  = 1'b1;
        spare_valid_d = push;
        if (push) begin
          spare_data_d = s_data;
          spare_keep_d = s_keep;
          spare_last_d = s_last;
          spare_tid_d  = s_tid;
        end
      end else begin
        head_valid_d = push;
        if (push) begin
          head_data_d = s_data;
          head_keep_d = s_keep;
          head_last_d = s_last;
          head_tid_d  = s_tid;
        end
      end
    end else if (push) begin
      // Head is stalled: the spare slot is guaranteed free because s_ready_q was high.
      spare_data_d  = s_data;
      spare_keep_d  = s_keep;
      spare_last_d  = s_last;
      spare_tid_d   = s_tid;
      spare_valid_d = 1'b1;
    end

    s_ready_d = !spare_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q   <= '0;
      head_keep_q   <= '0;
      head_last_q   <= 1'b0;
      head_tid_q    <= '0;
      head_valid_q  <= 1'b0;
      spare_data_q  <= '0;
      spare_keep_q  <= '0;
      spare_last_q  <= 1'b0;
      spare_tid_q   <= '0;
      spare_valid_q <= 1'b0;
      s_ready_q     <= 1'b1;
    end else begin
      head_data_q   <= head_data_d;
      head_keep_q   <= head_keep_d;
      head_last_q   <= head_last_d;
      head_tid_q    <= head_tid_d;
      head_valid_q  <= head_valid_d;
      spare_data_q  <= spare_data_d;
      spare_keep_q  <= spare_keep_d;
      spare_last_q  <= spare_last_d;
      spare_tid_q   <= spare_tid_d;
      spare_valid_q <= spare_valid_d;
      s_ready_q     <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_data  = head_data_q;
  assign m_keep  = head_keep_q;
  assign m_last  = head_last_q;
  assign m_tid   = head_tid_q;
  assign m_valid = head_valid_q;

endmodule

// File: rtl/eth_axis_frame_arbiter_256b.sv
// Frame-granular round-robin arbiter merging PORTS receive streams onto one 256-bit path,
// tagging each beat with its source port and forwarding through a registered skid stage.
module eth_axis_frame_arbiter_256b
  import eth_axis_pkg::*;
#(
  parameter int unsigned PORTS  = 2,
  parameter int unsigned PORT_W = $clog2(PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*ETH_DATA_W-1:0] s_axis_tdata,
  input  logic [PORTS*ETH_KEEP_W-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]           s_axis_tvalid,
  output logic [PORTS-1:0]           s_axis_tready,
  input  logic [PORTS-1:0]           s_axis_tlast,
  input  logic [PORTS-1:0]           port_enable,
  output logic [ETH_DATA_W-1:0]      m_axis_tdata,
  output logic [ETH_KEEP_W-1:0]      m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [PORT_W-1:0]          m_axis_tid,
  output logic                       busy,
  output logic [PORT_W-1:0]          grant_port
);

  // First requester strictly after last, wrapping modulo PORTS.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [PORTS-1:0]  req,
                                                input logic [PORT_W-1:0] last);
    logic [PORT_W-1:0] pick;
    logic [PORT_W-1:0] idx_w;
    logic              found;
    int unsigned       idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      idx   = (32'(last) + i) % PORTS;
      idx_w = PORT_W'(idx);
      if (!found && req[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_t        state_q, state_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [PORT_W-1:0] last_q, last_d;
  logic [PORTS-1:0]  req;

  logic [ETH_DATA_W-1:0] sel_data;
  logic [ETH_KEEP_W-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  skid_s_valid;
  logic                  skid_s_ready;

  assign req = s_axis_tvalid & port_enable;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant_q == PORT_W'(p)) begin
        sel_data  = s_axis_tdata[p*ETH_DATA_W +: ETH_DATA_W];
        sel_keep  = s_axis_tkeep[p*ETH_KEEP_W +: ETH_KEEP_W];
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    s_axis_tready = '0;
    skid_s_valid  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = rr_pick(req, last_q);
          state_d = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        for (int unsigned p = 0; p < PORTS; p++) begin
          s_axis_tready[p] = skid_s_ready && (grant_q == PORT_W'(p));
        end
        skid_s_valid = sel_valid;
        // port_enable is deliberately ignored here so a started frame always completes.
        if (sel_valid && skid_s_ready && sel_last) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= PORT_W'(PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign busy       = (state_q == ARB_GRANTED);
  assign grant_port = grant_q;

  eth_axis_skid_256b #(
    .TID_W (PORT_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (sel_data),
    .s_keep  (sel_keep),
    .s_last  (sel_last),
    .s_tid   (grant_q),
    .s_valid (skid_s_valid),
    .s_ready (skid_s_ready),
    .m_data  (m_axis_tdata),
    .m_keep  (m_axis_tkeep),
    .m_last  (m_axis_tlast),
    .m_tid   (m_axis_tid),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_eth_axis_frame_arbiter_256b.sv
// Scoreboard bench for the frame arbiter: accepted input beats are queued with their
// source port and compared against the output stream; arbitration order checked directly.
module tb_eth_axis_frame_arbiter_256b;

  localparam int unsigned P  = 4;
  localparam int unsigned PW = 2;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  typedef struct packed {
    logic [255:0]  d;
    logic [31:0]   k;
    logic          l;
    logic [PW-1:0] id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [P*256-1:0] s_axis_tdata = '0;
  logic [P*32-1:0]  s_axis_tkeep = '0;
  logic [P-1:0]     s_axis_tvalid = '0;
  logic [P-1:0]     s_axis_tready;
  logic [P-1:0]     s_axis_tlast = '0;
  logic [P-1:0]     port_enable = '0;
  logic [255:0]     m_axis_tdata;
  logic [31:0]      m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [PW-1:0]    m_axis_tid;
  logic             busy;
  logic [PW-1:0]    grant_port;

  always #5 clk = ~clk;

  eth_axis_frame_arbiter_256b #(
    .PORTS (P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .port_enable   (port_enable),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy),
    .grant_port    (grant_port)
  );

  beat_t        src_q[P][$];
  exp_t         sb[$];
  int           out_tid[$];
  int           out_cyc[$];
  logic [P-1:0] hold = '0;
  int           acc[P];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           ready_viol = 0;
  int           intl_viol = 0;
  bit           in_frame = 1'b0;
  logic [PW-1:0] frame_tid = '0;
  bit           stall_prev = 1'b0;
  logic [319:0] stall_val = '0;

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int p, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) b.d[w*32 +: 32] = $urandom();
      b.k = $urandom();
      b.l = (i == n - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      if (src_q[p].size() > 0 && !hold[p]) begin
        s_axis_tvalid[p]           = 1'b1;
        s_axis_tdata[p*256 +: 256] = src_q[p][0].d;
        s_axis_tkeep[p*32 +: 32]   = src_q[p][0].k;
        s_axis_tlast[p]            = src_q[p][0].l;
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [P-1:0] hs;
    exp_t         e;
    logic [319:0] cur;
    hs = '0;
    drive();
    @(negedge clk);
    if (rst_n) begin
      cur = {28'd0, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid};
      if (stall_prev) check_eq("hold_stable", cur, stall_val);
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_val  = cur;
      if ($countones(s_axis_tready) > 1) ready_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 320'(m_axis_tid), 320'hdead);
        end else begin
          e = sb.pop_front();
          check_eq("beat", 320'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid}),
                   320'(e));
        end
        if (in_frame && m_axis_tid != frame_tid) intl_viol++;
        in_frame  = !m_axis_tlast;
        frame_tid = m_axis_tid;
        out_tid.push_back(int'(m_axis_tid));
        out_cyc.push_back(cyc);
      end
      hs = s_axis_tvalid & s_axis_tready;
      for (int p = 0; p < P; p++) begin
        if (hs[p]) begin
          e.d  = src_q[p][0].d;
          e.k  = src_q[p][0].k;
          e.l  = src_q[p][0].l;
          e.id = PW'(p);
          sb.push_back(e);
          acc[p]++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < P; p++) if (hs[p]) void'(src_q[p].pop_front());
  endtask

  task automatic drain(input int limit);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < limit) begin
      tick();
      n++;
      pending = (sb.size() != 0);
      for (int p = 0; p < P; p++) if (src_q[p].size() != 0) pending = 1'b1;
    end
    if (pending) check_eq("drain_timeout", 320'(1), 320'(0));
  endtask

  task automatic clear_log();
    out_tid.delete();
    out_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    int viol;
    int n;
    int cnt0;
    int cnt1;
    int exp_rel[6];
    int exp_id[6];

    for (int p = 0; p < P; p++) acc[p] = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_m_valid", 320'(m_axis_tvalid), 320'(0));
    check_eq("rst_m_data", 320'(m_axis_tdata), 320'(0));
    check_eq("rst_m_keep", 320'(m_axis_tkeep), 320'(0));
    check_eq("rst_m_last", 320'(m_axis_tlast), 320'(0));
    check_eq("rst_m_tid", 320'(m_axis_tid), 320'(0));
    check_eq("rst_s_ready", 320'(s_axis_tready), 320'(0));
    check_eq("rst_busy", 320'(busy), 320'(0));
    check_eq("rst_grant", 320'(grant_port), 320'(0));

    // Two ports, 3-beat frames presented together
    port_enable = 4'b0011;
    clear_log();
    load_frame(0, 3);
    load_frame(1, 3);
    c0 = cyc;
    drain(100);
    exp_rel = '{2, 3, 4, 6, 7, 8};
    exp_id  = '{0, 0, 0, 1, 1, 1};
    check_eq("t1_count", 320'(out_tid.size()), 320'(6));
    for (int i = 0; i < 6 && i < out_tid.size(); i++) begin
      check_eq($sformatf("t1_cyc%0d", i), 320'(out_cyc[i] - c0), 320'(exp_rel[i]));
      check_eq($sformatf("t1_tid%0d", i), 320'(out_tid[i]), 320'(exp_id[i]));
    end

    // Enable cleared mid-frame on port 1
    port_enable = 4'b0011;
    clear_log();
    base = acc[1];
    load_frame(1, 5);
    n = 0;
    while (acc[1] - base < 2 && n < 30) begin tick(); n++; end
    check_eq("t3_reach_beat2", 320'(acc[1] - base), 320'(2));
    check_eq("t3_grant", 320'({busy, grant_port}), 320'({1'b1, 2'd1}));
    port_enable = 4'b0001;
    load_frame(1, 2);
    load_frame(0, 2);
    viol = 0;
    repeat (25) begin
      tick();
      if (acc[1] - base >= 5 && busy && grant_port == 2'd1) viol++;
    end
    cnt0 = 0;
    cnt1 = 0;
    foreach (out_tid[i]) begin
      if (out_tid[i] == 0) cnt0++;
      if (out_tid[i] == 1) cnt1++;
    end
    check_eq("t3_no_regrant", 320'(viol), 320'(0));
    check_eq("t3_p1_beats", 320'(cnt1), 320'(5));
    check_eq("t3_p0_beats", 320'(cnt0), 320'(2));
    check_eq("t3_p1_pending", 320'(src_q[1].size()), 320'(2));
    port_enable = 4'b0011;
    drain(100);

    // Downstream stall absorbs exactly two beats
    repeat (3) tick();
    m_axis_tready = 1'b0;
    base = acc[0];
    load_frame(0, 5);
    repeat (10) tick();
    check_eq("t4_absorbed", 320'(acc[0] - base), 320'(2));
    check_eq("t4_s_ready_low", 320'(s_axis_tready), 320'(0));
    check_eq("t4_m_valid", 320'(m_axis_tvalid), 320'(1));
    m_axis_tready = 1'b1;
    drain(100);

    // Granted port pauses while the other port requests
    clear_log();
    load_frame(0, 6);
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    check_eq("t6_grant0", 320'({busy, grant_port}), 320'({1'b1, 2'd0}));
    load_frame(1, 3);
    base = acc[0];
    n = 0;
    while (acc[0] - base < 2 && n < 30) begin tick(); n++; end
    hold[0] = 1'b1;
    viol = 0;
    repeat (4) begin
      tick();
      if (s_axis_tready[1] || grant_port != 2'd0 || !busy) viol++;
    end
    check_eq("t6_grant_held", 320'(viol), 320'(0));
    hold[0] = 1'b0;
    drain(100);
    check_eq("t6_count", 320'(out_tid.size()), 320'(9));
    for (int i = 0; i < 9 && i < out_tid.size(); i++)
      check_eq($sformatf("t6_tid%0d", i), 320'(out_tid[i]), 320'(i < 6 ? 0 : 1));

    // Asynchronous reset mid-frame
    load_frame(1, 8);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin tick(); n++; end
    check_eq("t5_pre_valid", 320'(m_axis_tvalid), 320'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_m_valid", 320'(m_axis_tvalid), 320'(0));
    check_eq("t5_async_s_ready", 320'(s_axis_tready), 320'(0));
    check_eq("t5_async_busy", 320'(busy), 320'(0));
    for (int p = 0; p < P; p++) src_q[p].delete();
    sb.delete();
    hold       = '0;
    stall_prev = 1'b0;
    in_frame   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Four ports, continuous single-beat frames, priority restarts at port 0
    port_enable = 4'b1111;
    clear_log();
    for (int p = 0; p < P; p++) for (int f = 0; f < 4; f++) load_frame(p, 1);
    drain(200);
    check_eq("t2_count", 320'(out_tid.size()), 320'(16));
    for (int i = 0; i < 16 && i < out_tid.size(); i++)
      check_eq($sformatf("t2_tid%0d", i), 320'(out_tid[i]), 320'(i % 4));

    check_eq("tready_onehot", 320'(ready_viol), 320'(0));
    check_eq("no_interleave", 320'(intl_viol), 320'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_axis_frame_arbiter_256b.md
# eth_axis_frame_arbiter_256b

Packet-granular round-robin arbiter that shares one 256-bit AXI4-Stream Ethernet path, typically the FCS checker, between `PORTS` receive streams. It grants one input for a whole frame, from first beat to `tlast`, so frames are never interleaved. It tags every output beat with its source port and forwards through a registered skid stage. The block sits between the per-link receive paths and the single shared FCS-check / frame-processing chain.

## Interface
Parameters:
- `PORTS`, default 2: number of input streams; legal range 2..8.
- `PORT_W`, default `$clog2(PORTS)`: width of the source tag. Derived; do not override.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_axis_tdata`, in, `PORTS*256`: port p occupies bits `[p*256 +: 256]`.
- `s_axis_tkeep`, in, `PORTS*32`: passed through unchanged.
- `s_axis_tvalid`, in, `PORTS`: per-port valid.
- `s_axis_tready`, out, `PORTS`: per-port ready. At most one bit is high in any cycle.
- `s_axis_tlast`, in, `PORTS`: per-port end of frame.
- `port_enable`, in, `PORTS`: configuration mask. A disabled port is never newly granted.
- `m_axis_tdata`, out, 256: forwarded data.
- `m_axis_tkeep`, out, 32: forwarded keep.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: forwarded end of frame.
- `m_axis_tid`, out, `PORT_W`: source port of the current output beat.
- `busy`, out, 1: high while the FSM is in GRANTED.
- `grant_port`, out, `PORT_W`: currently or most recently granted port.

## Operation
- FSM states are IDLE and GRANTED. Reset enters IDLE with `last_grant = PORTS-1`, so port 0 has first priority.
- IDLE:
  - All `s_axis_tready` are 0.
  - Request vector = `s_axis_tvalid & port_enable`.
  - If the request vector is nonzero, select the first requesting port searching upward from `last_grant+1`, wrapping modulo `PORTS`. Register the selection into `grant_port` and go to GRANTED.
- GRANTED:
  - `s_axis_tready[grant_port] = skid_s_ready`; every other ready bit is 0.
  - Each accepted beat enters the skid stage with `tid = grant_port`.
  - When the accepted beat has `tlast = 1`, set `last_grant <= grant_port` and return to IDLE.
- Clearing `port_enable[grant_port]` mid-frame does not abort the frame. The frame completes, and the port is excluded from the next arbitration.
- The block neither inspects nor modifies payload, `tkeep` or frame length. Frames of any length, including one beat, are legal.
- A granted port may drop `tvalid` mid-frame. The grant is held indefinitely; there is no timeout.
- Reset mid-frame: all state and the skid contents clear immediately, and the partial frame is lost. The downstream frame FIFO sees a truncated frame, and upstream must restart its frames after reset.
- Arithmetic: round-robin search and wrap are modulo `PORTS`. `PORT_W` is at least 1.

## Timing
- Reset values:
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `m_axis_tid` = 0.
  - `s_axis_tready` = 0, `busy` = 0, `grant_port` = 0.
- Arbitration costs one cycle. The first beat of a frame is accepted no earlier than the cycle after the request is seen in IDLE.
- The minimum gap between frames is one cycle, so sustained throughput is N/(N+1) beats/cycle for N-beat frames.
- Output latency: a beat accepted at edge k appears on `m_axis_*` after edge k, i.e. one cycle.
- Skid stage rules:
  - It has two entries.
  - `skid_s_ready` is a registered signal, so `s_axis_tready` has no combinational path from `m_axis_tready`.
  - Full throughput is maintained while `m_axis_tready` stays high.
  - With `m_axis_tready` low, at most 2 beats are absorbed before `s_axis_tready` falls.
- AXI rules: `m_axis_*` are held stable while `m_axis_tvalid && !m_axis_tready`. Once asserted, `m_axis_tvalid` does not drop until the handshake completes.
- Simultaneous events: a `tlast` handshake and a new request in the same cycle resolve to GRANTED→IDLE first. The new request is arbitrated in the following cycle.

## Structure
- Shared package `eth_axis_pkg` holds:
  - `ETH_DATA_W = 256` and `ETH_KEEP_W = 32`.
  - `typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t`.
- One sub-module, `eth_axis_skid_256b`: a 2-entry register slice carrying data, keep, last and tid, with registered `s_ready`, clocked by `clk` with asynchronous reset `rst_n`.
- The round-robin picker is a function inside the arbiter, not a separate module.

## Test plan
- Two ports with `port_enable = 2'b11` both present a 3-beat frame at cycle 0. Expected output: port 0 frame with `tid = 0`, beats at cycles 2–4; a one-cycle gap; then the port 1 frame with `tid = 1`. No interleaving occurs.
- Four ports all continuously requesting single-beat frames. The grant order is 0,1,2,3,0,…, and every output beat is valid with `tlast = 1`.
- Port 1 is granted, and `port_enable[1]` is cleared after beat 2 of a 5-beat frame. All 5 beats are forwarded, and port 1 is not granted again while disabled.
- `m_axis_tready` is held low for 10 cycles during a frame. Exactly 2 beats are absorbed, `s_axis_tready` falls, the output stays stable, and no beat is lost or duplicated after release.
- `rst_n` is asserted asynchronously mid-frame, between clock edges. `m_axis_tvalid`, all `s_axis_tready` and `busy` go to 0 without waiting for a clock edge. After release, port 0 has priority again.
- The granted port drops `tvalid` for 4 cycles mid-frame while the other port requests. The grant is held, and the other port is not serviced until the current frame's `tlast`.
